// File: rtl/doom_input_pkg.sv
// Shared types and scancode constants for the PS/2 keyboard input path.
// Imported by ps2_line_filter and ps2_key_rx.
package doom_input_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_FIRE  = 8'h29;
    localparam logic [7:0] SC_START = 8'h5A;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(
        input logic [7:0] b,
        input logic       p
    );
        return ^{b, p};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// 2-flop synchroniser, glitch filter and falling-edge strobe for PS/2 clock.
// Ports: clk, rst (sync, active-low), line_i (raw), filt_o, fall_o (1-cycle).
module ps2_line_filter
    import doom_input_pkg::*;
#(
    parameter int FILTER_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic filt_o,
    output logic fall_o
);

    localparam int CW = (FILTER_CYCLES > 2) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          f_q, f_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            f_q    <= 1'b1;
            fall_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            f_q    <= f_d;
            fall_q <= fall_d;
            cnt_q  <= cnt_d;
        end
    end

    // Count consecutive synced samples that disagree with the filtered
    // level; any agreeing sample restarts the count.
    always_comb begin
        s1_d   = line_i;
        s2_d   = s1_q;
        f_d    = f_q;
        fall_d = 1'b0;
        cnt_d  = '0;
        if (s2_q != f_q) begin
            if (cnt_q == CNT_LAST) begin
                f_d    = s2_q;
                fall_d = f_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign filt_o = f_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: frames -> scancode events plus held-key levels.
// Ports: clk, rst (sync, active-low), ps2_clk, ps2_data; code_valid, code,
// code_ext, code_break, frame_err; key_left/right/fire/start levels.
// Option: PS2_TYPEMATIC_FILTER_EN drops repeat makes of held mapped keys.
module ps2_key_rx
    import doom_input_pkg::*;
#(
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       code_valid,
    output logic [7:0] code,
    output logic       code_ext,
    output logic       code_break,
    output logic       frame_err,
    output logic       key_left,
    output logic       key_right,
    output logic       key_fire,
    output logic       key_start
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic strobe;
    logic filt_unused;

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filt (
        .clk    (clk),
        .rst    (rst),
        .line_i (ps2_clk),
        .filt_o (filt_unused),
        .fall_o (strobe)
    );

    rx_state_e     state_q, state_d;
    logic          d1_q, d2_q;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ext_q, ext_d;
    logic          brk_q, brk_d;
    logic          valid_q, valid_d;
    logic [7:0]    code_q, code_d;
    logic          cext_q, cext_d;
    logic          cbrk_q, cbrk_d;
    logic          err_q, err_d;
    logic          left_q, left_d;
    logic          right_q, right_d;
    logic          fire_q, fire_d;
    logic          start_q, start_d;
    logic          make;
    logic          repeat_hit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            d1_q    <= 1'b1;
            d2_q    <= 1'b1;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tmo_q   <= '0;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            valid_q <= 1'b0;
            code_q  <= '0;
            cext_q  <= 1'b0;
            cbrk_q  <= 1'b0;
            err_q   <= 1'b0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            fire_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            d1_q    <= ps2_data;
            d2_q    <= d1_q;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tmo_q   <= tmo_d;
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            cext_q  <= cext_d;
            cbrk_q  <= cbrk_d;
            err_q   <= err_d;
            left_q  <= left_d;
            right_q <= right_d;
            fire_q  <= fire_d;
            start_q <= start_d;
        end
    end

    // A make for a key whose level is already high is a typematic repeat.
    assign make = !brk_q;
    assign repeat_hit = make && (ext_q
        ? ((shift_q == SC_LEFT && left_q) || (shift_q == SC_RIGHT && right_q))
        : ((shift_q == SC_FIRE && fire_q) || (shift_q == SC_START && start_q)));

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tmo_d   = '0;
        ext_d   = ext_q;
        brk_d   = brk_q;
        valid_d = 1'b0;
        code_d  = code_q;
        cext_d  = cext_q;
        cbrk_d  = cbrk_q;
        err_d   = 1'b0;
        left_d  = left_q;
        right_d = right_q;
        fire_d  = fire_q;
        start_d = start_q;

        if (state_q != IDLE && !strobe && tmo_q == TMO_LAST) begin
            // Stalled frame: abandon it along with any pending prefix.
            err_d   = 1'b1;
            state_d = IDLE;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
        end else begin
            if (state_q != IDLE && !strobe) begin
                tmo_d = tmo_q + 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (strobe && !d2_q) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
                end
                DATA: begin
                    if (strobe) begin
                        shift_d = {d2_q, shift_q[7:1]};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == 3'd7) begin
                            state_d = PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (strobe) begin
                        par_d   = d2_q;
                        state_d = STOP;
                    end
                end
                STOP: begin
                    if (strobe) begin
                        state_d = IDLE;
                        if (!(odd_parity_ok(shift_q, par_q) && d2_q)) begin
                            err_d = 1'b1;
                        end else if (shift_q == SC_EXT) begin
                            ext_d = 1'b1;
                        end else if (shift_q == SC_BREAK) begin
                            brk_d = 1'b1;
                        end else begin
                            ext_d = 1'b0;
                            brk_d = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
                            valid_d = !repeat_hit;
`else
                            valid_d = 1'b1;
`endif
                            if (valid_d) begin
                                code_d = shift_q;
                                cext_d = ext_q;
                                cbrk_d = brk_q;
                            end
                            if (ext_q) begin
                                if (shift_q == SC_LEFT)  left_d  = make;
                                if (shift_q == SC_RIGHT) right_d = make;
                            end else begin
                                if (shift_q == SC_FIRE)  fire_d  = make;
                                if (shift_q == SC_START) start_d = make;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign code_valid = valid_q;
    assign code       = code_q;
    assign code_ext   = cext_q;
    assign code_break = cbrk_q;
    assign frame_err  = err_q;
    assign key_left   = left_q;
    assign key_right  = right_q;
    assign key_fire   = fire_q;
    assign key_start  = start_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Self-checking bench for ps2_key_rx: frame table plus corner sequences.
// Short PS/2 bit period and timeout keep the run small.
module tb_ps2_key_rx;

    localparam int H    = 20;
    localparam int TMO  = 2000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       code_valid;
    logic [7:0] code;
    logic       code_ext;
    logic       code_break;
    logic       frame_err;
    logic       key_left;
    logic       key_right;
    logic       key_fire;
    logic       key_start;

    always #5 clk = ~clk;

    ps2_key_rx #(.FILTER_CYCLES(8), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .code_valid (code_valid),
        .code       (code),
        .code_ext   (code_ext),
        .code_break (code_break),
        .frame_err  (frame_err),
        .key_left   (key_left),
        .key_right  (key_right),
        .key_fire   (key_fire),
        .key_start  (key_start)
    );

    typedef struct {
        logic [7:0] b;
        logic       ext;
        logic       brk;
    } ev_t;

    typedef struct {
        logic [7:0] b;
        bit         bad;
        bit         valid;
        bit         ext;
        bit         brk;
        bit         err;
        logic [3:0] keys;
    } vec_t;

    ev_t  sb[$];
    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;
    int   err_seen = 0;
    int   exp_err = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (code_valid && frame_err) begin
            chk("valid_and_err_same_cycle", 1, 0);
        end
        if (frame_err) err_seen++;
        if (code_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_code_valid", {23'd0, code_ext, code_break, code}, 32'hFFFF);
            end else begin
                ev_t e;
                e = sb.pop_front();
                chk("code", {24'd0, code}, {24'd0, e.b});
                chk("code_ext", {31'd0, code_ext}, {31'd0, e.ext});
                chk("code_break", {31'd0, code_break}, {31'd0, e.brk});
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Sends the first nbits of a frame; optional 7-cycle low glitch on
    // ps2_clk after bit glitch_after while the line is high.
    task automatic send(input logic [7:0] b, input bit bad, input int nbits,
                        input int glitch_after);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            clks(H);
            ps2_clk = 1'b0;
            clks(H);
            ps2_clk = 1'b1;
            if (i == glitch_after) begin
                clks(5);
                ps2_clk = 1'b0;
                clks(7);
                ps2_clk = 1'b1;
            end
        end
        clks(H);
        ps2_data = 1'b1;
    endtask

    task automatic frame(input logic [7:0] b, input bit exp_v,
                         input bit ext, input bit brk);
        if (exp_v) sb.push_back('{b, ext, brk});
        send(b, 1'b0, 11, -1);
        clks(20);
        chk("pending_code_valid", sb.size(), 0);
    endtask

    function automatic logic [3:0] keys();
        return {key_start, key_fire, key_right, key_left};
    endfunction

    initial begin
        tbl.push_back('{8'h29, 0, 1, 0, 0, 0, 4'b0100});
        tbl.push_back('{8'hF0, 0, 0, 0, 0, 0, 4'b0100});
        tbl.push_back('{8'h29, 0, 1, 0, 1, 0, 4'b0000});
        tbl.push_back('{8'hE0, 0, 0, 0, 0, 0, 4'b0000});
        tbl.push_back('{8'h6B, 0, 1, 1, 0, 0, 4'b0001});
        tbl.push_back('{8'hE0, 0, 0, 0, 0, 0, 4'b0001});
        tbl.push_back('{8'hF0, 0, 0, 0, 0, 0, 4'b0001});
        tbl.push_back('{8'h6B, 0, 1, 1, 1, 0, 4'b0000});
        tbl.push_back('{8'h29, 1, 0, 0, 0, 1, 4'b0000});
        tbl.push_back('{8'h5A, 0, 1, 0, 0, 0, 4'b1000});
        tbl.push_back('{8'hE0, 0, 0, 0, 0, 0, 4'b1000});
        tbl.push_back('{8'h29, 1, 0, 0, 0, 1, 4'b1000});
        tbl.push_back('{8'h74, 0, 1, 1, 0, 0, 4'b1010});
        tbl.push_back('{8'hE0, 0, 0, 0, 0, 0, 4'b1010});
        tbl.push_back('{8'hF0, 0, 0, 0, 0, 0, 4'b1010});
        tbl.push_back('{8'h74, 0, 1, 1, 1, 0, 4'b1000});
        tbl.push_back('{8'h6B, 0, 1, 0, 0, 0, 4'b1000});
        tbl.push_back('{8'hE0, 0, 0, 0, 0, 0, 4'b1000});
        tbl.push_back('{8'hF0, 0, 0, 0, 0, 0, 4'b1000});
        tbl.push_back('{8'h5A, 0, 1, 1, 1, 0, 4'b1000});

        rst = 1'b0;
        clks(5);
        @(negedge clk);
        chk("reset_outputs", {code_valid, code, code_ext, code_break,
                              frame_err, keys()}, 0);
        rst = 1'b1;
        clks(10);

        foreach (tbl[i]) begin
            if (tbl[i].valid) sb.push_back('{tbl[i].b, tbl[i].ext, tbl[i].brk});
            send(tbl[i].b, tbl[i].bad, 11, -1);
            clks(20);
            exp_err += int'(tbl[i].err);
            chk($sformatf("vec%0d_pending", i), sb.size(), 0);
            chk($sformatf("vec%0d_keys", i), {28'd0, keys()}, {28'd0, tbl[i].keys});
            chk($sformatf("vec%0d_errs", i), err_seen, exp_err);
        end

        // Timeout mid-frame also drops a pending E0.
        frame(8'hE0, 0, 0, 0);
        send(8'h74, 1'b0, 5, -1);
        clks(1800);
        chk("no_early_timeout", err_seen, exp_err);
        clks(400);
        exp_err++;
        chk("timeout_err", err_seen, exp_err);
        frame(8'h74, 1, 0, 0);
        chk("timeout_keys", {28'd0, keys()}, 32'b1000);

        // Short glitch on ps2_clk must not add a bit.
        frame(8'hF0, 0, 0, 0);
        sb.push_back('{8'h5A, 1'b0, 1'b1});
        send(8'h5A, 1'b0, 11, 3);
        clks(20);
        chk("glitch_pending", sb.size(), 0);
        chk("glitch_keys", {28'd0, keys()}, 0);
        chk("glitch_errs", err_seen, exp_err);

        // Reset mid-frame clears keys, outputs and the pending prefix.
        frame(8'h29, 1, 0, 0);
        chk("pre_reset_keys", {28'd0, keys()}, 32'b0100);
        frame(8'hE0, 0, 0, 0);
        send(8'h74, 1'b0, 5, -1);
        @(posedge clk);
        rst = 1'b0;
        clks(3);
        @(negedge clk);
        chk("midframe_reset_outputs", {code_valid, code, code_ext, code_break,
                                       frame_err, keys()}, 0);
        rst = 1'b1;
        clks(10);
        frame(8'h29, 1, 0, 0);
        chk("post_reset_keys", {28'd0, keys()}, 32'b0100);

        // Typematic repeat of a held key.
`ifdef PS2_TYPEMATIC_FILTER_EN
        frame(8'h29, 0, 0, 0);
`else
        frame(8'h29, 1, 0, 0);
`endif
        chk("repeat_keys", {28'd0, keys()}, 32'b0100);
        frame(8'hF0, 0, 0, 0);
        frame(8'h29, 1, 0, 1);
        chk("final_keys", {28'd0, keys()}, 0);
        chk("final_errs", err_seen, exp_err);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
